// File: rtl/peripheral_uart_pkg.sv
// Shared definitions for the UART RX status slice.
// Holds the RX FIFO trigger levels, the IIR interrupt identification codes,
// the bit positions used inside the LSR and inside the RX-side lsr_rx vector,
// and the bit positions of the per-character status inside a FIFO word.
package peripheral_uart_pkg;

  // RX FIFO trigger levels selected by FCR[7:6]
  localparam int unsigned UART_TRIG_LVL_1  = 1;
  localparam int unsigned UART_TRIG_LVL_4  = 4;
  localparam int unsigned UART_TRIG_LVL_8  = 8;
  localparam int unsigned UART_TRIG_LVL_14 = 14;

  // Interrupt identification codes (IIR[3:0])
  localparam logic [3:0] UART_II_RLS  = 4'b0110;
  localparam logic [3:0] UART_II_RDA  = 4'b0100;
  localparam logic [3:0] UART_II_TI   = 4'b1100;
  localparam logic [3:0] UART_II_NONE = 4'b0001;

  // Bit positions in the full Line Status Register
  localparam int UART_LSR_DR  = 0;
  localparam int UART_LSR_OE  = 1;
  localparam int UART_LSR_PE  = 2;
  localparam int UART_LSR_FE  = 3;
  localparam int UART_LSR_BI  = 4;
  localparam int UART_LSR_ERR = 7;

  // Bit positions in the packed 6-bit RX half {fifo_err, BI, FE, PE, OE, DR}
  localparam int UART_RX_DR  = 0;
  localparam int UART_RX_OE  = 1;
  localparam int UART_RX_PE  = 2;
  localparam int UART_RX_FE  = 3;
  localparam int UART_RX_BI  = 4;
  localparam int UART_RX_ERR = 5;

  // Status bits of the head character in the RX FIFO word
  localparam int UART_REC_FE = 0;
  localparam int UART_REC_PE = 1;
  localparam int UART_REC_BI = 2;

  // Maps the FCR trigger select onto the FIFO occupancy that raises RDA
  function automatic int unsigned trigger_level(input logic [1:0] sel);
    int unsigned lvl;
    case (sel)
      2'b00:   lvl = UART_TRIG_LVL_1;
      2'b01:   lvl = UART_TRIG_LVL_4;
      2'b10:   lvl = UART_TRIG_LVL_8;
      default: lvl = UART_TRIG_LVL_14;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/peripheral_uart_sticky_bit_wb.sv
// One sticky LSR error flag.
// The flag sets on a rising edge of its source and stays set until a clear
// strobe. A rising edge arriving in the same cycle as the clear wins, so an
// event that happens while software is reading the LSR is never lost.
// Ports:
//   clk        system clock
//   wb_rst_ni  asynchronous active-low reset
//   src        level source of the event
//   clr        clear strobe (LSR read pulse and/or FIFO reset)
//   out        sticky flag, registered
module peripheral_uart_sticky_bit_wb (
  input  logic clk,
  input  logic wb_rst_ni,
  input  logic src,
  input  logic clr,
  output logic out
);

  logic r_src_d;
  logic r_out;

  // Edge detection against the delayed source; set has priority over clear
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_src_d <= 1'b0;
      r_out   <= 1'b0;
    end else begin
      r_src_d <= src;
      if (src & ~r_src_d) begin
        r_out <= 1'b1;
      end else if (clr) begin
        r_out <= 1'b0;
      end
    end
  end

  assign out = r_out;

endmodule

// File: rtl/peripheral_uart_rx_status_wb.sv
// RX status block between the UART receiver FIFO and the Wishbone registers.
// Builds the RX half of the LSR, the RX interrupt sources, the RX part of the
// IIR code and the one-cycle LSR-read pulse that resets the FIFO status.
// Ports:
//   clk, wb_rst_ni   clock and asynchronous active-low reset
//   rf_count         RX FIFO occupancy
//   rf_data_out      RX FIFO head word, [2:0] = {break, parity, framing}
//   rf_overrun       FIFO overrun level
//   rf_error_bit     some character in the FIFO carries an error
//   counter_t        character timeout counter
//   rx_reset         RX FIFO reset strobe
//   lsr_read         LSR read strobe, may be held several cycles
//   fcr_trigger      RX trigger select
//   ier_rda, ier_rls interrupt enables
//   lsr_rx           {fifo_err, BI, FE, PE, OE, DR}
//   lsr_mask         one-cycle pulse per LSR read
//   rls_int, rda_int, ti_int  RX interrupt sources
//   iir_rx           highest-priority RX interrupt code
module peripheral_uart_rx_status_wb
  import peripheral_uart_pkg::*;
#(
  parameter int FIFO_COUNTER_W = 5,
  parameter int FIFO_REC_WIDTH = 11
) (
  input  logic                      clk,
  input  logic                      wb_rst_ni,
  input  logic [FIFO_COUNTER_W-1:0] rf_count,
  input  logic [FIFO_REC_WIDTH-1:0] rf_data_out,
  input  logic                      rf_overrun,
  input  logic                      rf_error_bit,
  input  logic [9:0]                counter_t,
  input  logic                      rx_reset,
  input  logic                      lsr_read,
  input  logic [1:0]                fcr_trigger,
  input  logic                      ier_rda,
  input  logic                      ier_rls,
  output logic [5:0]                lsr_rx,
  output logic                      lsr_mask,
  output logic                      rls_int,
  output logic                      rda_int,
  output logic                      ti_int,
  output logic [3:0]                iir_rx
);

  logic                      r_lsr_read_d;
  logic                      r_lsr_mask;
  logic                      r_dr;
  logic                      r_rls;
  logic                      r_rda;
  logic                      r_ti;
  logic [3:0]                r_iir;

  logic                      w_count_nz;
  logic [FIFO_COUNTER_W-1:0] w_trig_lvl;
  logic                      w_clr_rx;
  logic                      w_oe;
  logic                      w_pe;
  logic                      w_fe;
  logic                      w_bi;
  logic                      w_err;
  logic                      w_rls_next;
  logic                      w_rda_next;
  logic                      w_ti_next;
  logic [3:0]                w_iir_next;
  logic                      w_unused_rec;

  assign w_count_nz   = |rf_count;
  assign w_trig_lvl   = FIFO_COUNTER_W'(trigger_level(fcr_trigger));
  assign w_unused_rec = ^rf_data_out[FIFO_REC_WIDTH-1:3];

  // OE survives an RX FIFO reset: the overrun already happened on the line
  assign w_clr_rx = r_lsr_mask | rx_reset;

  peripheral_uart_sticky_bit_wb u_sticky_oe (
    .clk(clk), .wb_rst_ni(wb_rst_ni), .src(rf_overrun), .clr(r_lsr_mask), .out(w_oe)
  );
  peripheral_uart_sticky_bit_wb u_sticky_pe (
    .clk(clk), .wb_rst_ni(wb_rst_ni), .src(w_count_nz & rf_data_out[UART_REC_PE]),
    .clr(w_clr_rx), .out(w_pe)
  );
  peripheral_uart_sticky_bit_wb u_sticky_fe (
    .clk(clk), .wb_rst_ni(wb_rst_ni), .src(w_count_nz & rf_data_out[UART_REC_FE]),
    .clr(w_clr_rx), .out(w_fe)
  );
  peripheral_uart_sticky_bit_wb u_sticky_bi (
    .clk(clk), .wb_rst_ni(wb_rst_ni), .src(w_count_nz & rf_data_out[UART_REC_BI]),
    .clr(w_clr_rx), .out(w_bi)
  );
  peripheral_uart_sticky_bit_wb u_sticky_err (
    .clk(clk), .wb_rst_ni(wb_rst_ni), .src(rf_error_bit), .clr(w_clr_rx), .out(w_err)
  );

  // The timeout interrupt drops as soon as the counter is reloaded or the FIFO empties
  assign w_rls_next = ier_rls & (w_oe | w_pe | w_fe | w_bi);
  assign w_rda_next = ier_rda & (rf_count >= w_trig_lvl);
  assign w_ti_next  = ier_rda & w_count_nz & (counter_t == 10'd0);

  // IIR code is derived from the same next-state values so it lines up with the interrupts
  always_comb begin
    w_iir_next = UART_II_NONE;
    if (w_rls_next) begin
      w_iir_next = UART_II_RLS;
    end else if (w_rda_next) begin
      w_iir_next = UART_II_RDA;
    end else if (w_ti_next) begin
      w_iir_next = UART_II_TI;
    end
  end

  // lsr_mask fires once per read, no matter how long lsr_read stays high
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_lsr_read_d <= 1'b0;
      r_lsr_mask   <= 1'b0;
      r_dr         <= 1'b0;
      r_rls        <= 1'b0;
      r_rda        <= 1'b0;
      r_ti         <= 1'b0;
      r_iir        <= UART_II_NONE;
    end else begin
      r_lsr_read_d <= lsr_read;
      r_lsr_mask   <= lsr_read & ~r_lsr_read_d;
      r_dr         <= w_count_nz;
      r_rls        <= w_rls_next;
      r_rda        <= w_rda_next;
      r_ti         <= w_ti_next;
      r_iir        <= w_iir_next;
    end
  end

  always_comb begin
    lsr_rx              = '0;
    lsr_rx[UART_RX_DR]  = r_dr;
    lsr_rx[UART_RX_OE]  = w_oe;
    lsr_rx[UART_RX_PE]  = w_pe;
    lsr_rx[UART_RX_FE]  = w_fe;
    lsr_rx[UART_RX_BI]  = w_bi;
    lsr_rx[UART_RX_ERR] = w_err;
  end

  assign lsr_mask = r_lsr_mask;
  assign rls_int  = r_rls;
  assign rda_int  = r_rda;
  assign ti_int   = r_ti;
  assign iir_rx   = r_iir;

endmodule

// File: doc/peripheral_uart_rx_status_wb.md
Name: peripheral_uart_rx_status_wb

Overview:
- Downstream consumer of the UART receiver stage; sits between the receiver/RX FIFO and the Wishbone register file.
- Inputs: FIFO count, head-character status, overrun, error and timeout counter.
- Produces: the RX half of the Line Status Register (LSR), the RX interrupt sources (receiver line status, RX data available, character timeout), the RX part of the IIR code, and the LSR-read status pulse back to the FIFO.

Parameters:
- FIFO_COUNTER_W, 5, width of rf_count.
- FIFO_REC_WIDTH, 11, width of rf_data_out; bits [2:0] = {break, parity error, framing error} of the head character.

Ports:
- clk  in  1  system clock
- wb_rst_ni  in  1  reset, asynchronous, active-low
- rf_count  in  FIFO_COUNTER_W  RX FIFO occupancy
- rf_data_out  in  FIFO_REC_WIDTH  RX FIFO head word
- rf_overrun  in  1  FIFO overrun level
- rf_error_bit  in  1  any errored character in FIFO
- counter_t  in  10  character timeout counter
- rx_reset  in  1  RX FIFO reset strobe (FCR[1])
- lsr_read  in  1  LSR read strobe from register decode; may be held several cycles
- fcr_trigger  in  2  RX trigger select (FCR[7:6])
- ier_rda  in  1  IER[0], enables RDA and timeout interrupts
- ier_rls  in  1  IER[2], enables line status interrupt
- lsr_rx  out  6  {fifo_err, BI, FE, PE, OE, DR}, corresponding to LSR bits 7,4,3,2,1,0
- lsr_mask  out  1  one-cycle pulse to FIFO reset_status
- rls_int  out  1  line status interrupt
- rda_int  out  1  data available interrupt
- ti_int  out  1  character timeout interrupt
- iir_rx  out  4  highest-priority RX interrupt code

Behaviour:
- Reset (wb_rst_ni=0, asynchronous): all registers and all outputs are 0, except iir_rx, which resets to 4'b0001 (no interrupt).
- Clocking and latency:
  - Single clock.
  - All outputs are registered.
  - Each output reflects its inputs one cycle later.
- lsr_mask:
  - Rising edge of lsr_read (lsr_read=1 and its registered copy=0) gives lsr_mask=1 for exactly one cycle, in the cycle after the edge.
  - A held lsr_read gives exactly one pulse.
- DR = (rf_count != 0), registered. DR is never sticky.
- Sticky bits: OE, PE, FE, BI, fifo_err. Each bit has a source and a delayed copy of that source (src_d).
  - OE source: rf_overrun.
  - PE source: (rf_count!=0) & rf_data_out[1].
  - FE source: (rf_count!=0) & rf_data_out[0].
  - BI source: (rf_count!=0) & rf_data_out[2].
  - fifo_err source: rf_error_bit.
  - Set on a rising edge of the source (src & ~src_d).
  - Clear in the lsr_mask cycle.
  - A set edge in the same cycle as lsr_mask wins, so no event is lost.
  - rx_reset clears PE, FE, BI and fifo_err. OE is not affected by rx_reset.
- Trigger level from fcr_trigger: 00→1, 01→4, 10→8, 11→14.
- rda_int = ier_rda & (rf_count >= trigger level).
- ti_int:
  - Set when ier_rda & (rf_count!=0) & (counter_t==0).
  - Cleared when rf_count==0, when counter_t!=0 (counter reloaded by a pop or push), or when ier_rda=0.
- rls_int = ier_rls & (OE|PE|FE|BI), using the sticky values.
- iir_rx priority: RLS 4'b0110 > RDA 4'b0100 > TI 4'b1100 > none 4'b0001.
- Boundary conditions:
  - rf_count reaching exactly the trigger level asserts rda_int; dropping below it deasserts rda_int next cycle.
  - Trigger level 14 with rf_count=16 (full) keeps rda_int asserted.
  - fcr_trigger change mid-operation takes effect next cycle.

Decomposition:
- peripheral_uart_pkg gains:
  - trigger-level constants (1, 4, 8, 14);
  - IIR code constants (UART_II_RLS=4'b0110, UART_II_RDA=4'b0100, UART_II_TI=4'b1100, UART_II_NONE=4'b0001);
  - LSR bit index constants.
- One sub-module: peripheral_uart_sticky_bit_wb.
  - Function: rising-edge detect + sticky set/clear, set-priority.
  - Ports: clk, wb_rst_ni, src, clr, out.
  - Instantiated five times (OE, PE, FE, BI, fifo_err).

Test Plan:
- Reset: hold wb_rst_ni=0 mid-stream with rf_count=3 → lsr_rx=0, iir_rx=4'b0001, all interrupts 0 asynchronously; after release, DR=1 one cycle later.
- Framing error: rf_count=1, rf_data_out[0]=1, ier_rls=1 → FE=1, rls_int=1, iir_rx=4'b0110. lsr_read held 4 cycles → single lsr_mask pulse; FE clears.
- Trigger: fcr_trigger=01, ier_rda=1, push until rf_count 3→4 → rda_int rises the cycle after count=4, iir_rx=4'b0100; pop to 3 → rda_int=0.
- Timeout: rf_count=2, counter_t steps 1→0 → ti_int=1, iir_rx=4'b1100; counter_t reloaded to 639 → ti_int=0 next cycle.
- Collision: rf_overrun rises in the same cycle as lsr_mask → OE remains 1. A second LSR read then clears OE.
- rx_reset with PE=1 and OE=1 → PE=0, OE=1; rf_count forced 0 → DR=0 and ti_int=0.
